fpu_mul_exp_pipe: RTL and testbench



---
 rtl/fpu_mul_exp_pkg.sv | 22 ++
 rtl/fpu_mul_exp_pipe_if.sv | 34 +++
 rtl/fpu_mul_exp_stage.sv | 30 +++
 rtl/fpu_mul_exp_pipe.sv | 180 ++++++++++++++++++
 tb/tb_fpu_mul_exp_pipe.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fpu_mul_exp_pkg.sv
// Shared types and constants for the FPU multiply exponent pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a. Contents: format enum, single-precision constants, internal width helper.
package fpu_mul_exp_pkg;

    // Per-operation format select carried alongside the exponent down the pipe.
    typedef enum logic [1:0] {
        FMT_NATIVE = 2'd0,
        FMT_SNGL   = 2'd1,
        FMT_SMULD  = 2'd2,
        FMT_ZERO   = 2'd3
    } fmt_e;

    localparam int SNGL_BIAS = 127;
    localparam int SNGL_MAX  = 255;

    // Two extra bits: one for the carry of e1+e2, one for the sign after bias/lz subtraction.
    function automatic int int_w(input int exp_w);
        return exp_w + 2;
    endfunction

endpackage

// File: rtl/fpu_mul_exp_pipe_if.sv
// Bundle of step/flush control, per-operation inputs, side inputs and results for the exponent pipe.
// Latency: n/a (wires only).
// Backpressure: none; the shared step signal stalls the whole pipe. master = driver, slave = pipe.
interface fpu_mul_exp_pipe_if #(
    parameter int EXP_W = 11,
    parameter int LZ_W  = 7
);
    logic             step;
    logic             flush;
    logic             in_vld;
    logic [EXP_W-1:0] in_exp1;
    logic [EXP_W-1:0] in_exp2;
    logic [1:0]       in_fmt;
    logic [LZ_W-1:0]  norm_lz;
    logic             norm_inc;
    logic             rnd_cout;
    logic             to_inf;
    logic             out_vld;
    logic [EXP_W-1:0] out_exp;
    logic             out_ovf;
    logic             out_unf;

    modport master (
        output step, flush, in_vld, in_exp1, in_exp2, in_fmt,
               norm_lz, norm_inc, rnd_cout, to_inf,
        input  out_vld, out_exp, out_ovf, out_unf
    );

    modport slave (
        input  step, flush, in_vld, in_exp1, in_exp2, in_fmt,
               norm_lz, norm_inc, rnd_cout, to_inf,
        output out_vld, out_exp, out_ovf, out_unf
    );
endinterface

// File: rtl/fpu_mul_exp_stage.sv
// One {valid, data} pipe register advanced by step and cleared by flush.
// Latency: 1 step-qualified cycle.
// Backpressure: step=0 holds everything. Ports: clk, rst, step, flush, d_vld/d_dat in, q_vld/q_dat out.
module fpu_mul_exp_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         flush,
    input  logic         d_vld,
    input  logic [W-1:0] d_dat,
    output logic         q_vld,
    output logic [W-1:0] q_dat
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q_vld <= 1'b0;
            q_dat <= '0;
        end else begin
            if (flush)
                q_vld <= 1'b0;
            else if (step)
                q_vld <= d_vld;
            // Data only moves with a live operation, so bubbles and flushes leave it intact.
            if (step && d_vld && !flush)
                q_dat <= d_dat;
        end
    end
endmodule

// File: rtl/fpu_mul_exp_pipe.sv
// Multiply exponent pipe: biased sum/rebias, DEPTH-1 delays, leading-zero normalise, round and saturate.
// Latency: DEPTH+2 step-qualified cycles, one op per step.
// Backpressure: step=0 freezes all stages and outputs; flush clears valids only.
// Ports: rclk, rst (sync, active-high), bus (slave modport). Optional macro FPU_MUL_EXP_ERR_INJ_EN
// adds err_en/err_ctrl, which flip bit (err_ctrl mod INT_W) of the stage-A sum on capture.
module fpu_mul_exp_pipe
    import fpu_mul_exp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int BIAS  = 1023,
    parameter int LZ_W  = 7,
    parameter int DEPTH = 3
) (
    input  logic rclk,
    input  logic rst,
`ifdef FPU_MUL_EXP_ERR_INJ_EN
    input  logic       err_en,
    input  logic [3:0] err_ctrl,
`endif
    fpu_mul_exp_pipe_if.slave bus
);
    localparam int INT_W = int_w(EXP_W);

    typedef struct packed {
        logic [INT_W-1:0] sum;
        fmt_e             fmt;
    } sum_t;

    typedef struct packed {
        logic [INT_W-1:0] n;
        logic             unf;
        fmt_e             fmt;
    } norm_t;

    // ---------------- stage A: exponent sum with format rebias ----------------
    logic signed [INT_W-1:0] e1, e2, s1, s2, sum_raw;
    fmt_e                    fmt_in;
    sum_t                    a_in;
`ifdef FPU_MUL_EXP_ERR_INJ_EN
    logic [INT_W-1:0]        err_mask;
`endif

    always_comb begin
        fmt_in = fmt_e'(bus.in_fmt);
        e1 = $signed({{(INT_W-EXP_W){1'b0}}, bus.in_exp1});
        e2 = $signed({{(INT_W-EXP_W){1'b0}}, bus.in_exp2});
        // Single-precision exponent lives in the top 8 bits of the native field.
        s1 = $signed({{(INT_W-8){1'b0}}, bus.in_exp1[EXP_W-1 -: 8]});
        s2 = $signed({{(INT_W-8){1'b0}}, bus.in_exp2[EXP_W-1 -: 8]});
        case (fmt_in)
            FMT_NATIVE: sum_raw = e1 + e2 - $signed(INT_W'(BIAS));
            FMT_SNGL:   sum_raw = s1 + s2 - $signed(INT_W'(SNGL_BIAS));
            FMT_SMULD:  sum_raw = s1 + s2 + $signed(INT_W'(BIAS - 2*SNGL_BIAS));
            default:    sum_raw = '0;
        endcase
    end

`ifdef FPU_MUL_EXP_ERR_INJ_EN
    always_comb begin
        err_mask = '0;
        if (err_en)
            err_mask = {{(INT_W-1){1'b0}}, 1'b1} << (int'(err_ctrl) % INT_W);
    end
`endif

    always_comb begin
        a_in     = '0;
        a_in.fmt = fmt_in;
`ifdef FPU_MUL_EXP_ERR_INJ_EN
        a_in.sum = sum_raw ^ err_mask;
`else
        a_in.sum = sum_raw;
`endif
    end

    // ---------------- stage A plus delay stages D1..D(DEPTH-1) ----------------
    logic [DEPTH-1:0] st_vld;
    sum_t [DEPTH-1:0] st_dat;

    for (genvar i = 0; i < DEPTH; i++) begin : g_sum
        if (i == 0) begin : g_a
            fpu_mul_exp_stage #(.W($bits(sum_t))) u_stage (
                .clk   (rclk),
                .rst   (rst),
                .step  (bus.step),
                .flush (bus.flush),
                .d_vld (bus.in_vld),
                .d_dat (a_in),
                .q_vld (st_vld[0]),
                .q_dat (st_dat[0])
            );
        end else begin : g_d
            fpu_mul_exp_stage #(.W($bits(sum_t))) u_stage (
                .clk   (rclk),
                .rst   (rst),
                .step  (bus.step),
                .flush (bus.flush),
                .d_vld (st_vld[i-1]),
                .d_dat (st_dat[i-1]),
                .q_vld (st_vld[i]),
                .q_dat (st_dat[i])
            );
        end
    end

    // ---------------- normalise stage: subtract leading-zero count, clamp at 0 ----------------
    logic signed [INT_W-1:0] n_raw;
    norm_t                   n_in, n_q;
    logic                    n_vld;

    always_comb begin
        n_raw = $signed(st_dat[DEPTH-1].sum) - $signed({{(INT_W-LZ_W){1'b0}}, bus.norm_lz});
        n_in     = '0;
        n_in.fmt = st_dat[DEPTH-1].fmt;
        if (n_raw <= 0) begin
            n_in.n   = '0;
            n_in.unf = 1'b1;
        end else begin
            n_in.n   = n_raw;
            n_in.unf = 1'b0;
        end
    end

    fpu_mul_exp_stage #(.W($bits(norm_t))) u_norm (
        .clk   (rclk),
        .rst   (rst),
        .step  (bus.step),
        .flush (bus.flush),
        .d_vld (st_vld[DEPTH-1]),
        .d_dat (n_in),
        .q_vld (n_vld),
        .q_dat (n_q)
    );

    // ---------------- round stage / output register ----------------
    logic signed [INT_W-1:0] r, max_v;
    logic [EXP_W-1:0]        max_lo;
    logic                    o_vld, o_ovf, o_unf;
    logic [EXP_W-1:0]        o_exp;

    always_comb begin
        r = $signed(n_q.n)
          + $signed({{(INT_W-1){1'b0}}, bus.norm_inc})
          + $signed({{(INT_W-1){1'b0}}, bus.rnd_cout});
        max_v  = (n_q.fmt == FMT_SNGL) ? $signed(INT_W'(SNGL_MAX))
                                       : $signed({{(INT_W-EXP_W){1'b0}}, {EXP_W{1'b1}}});
        max_lo = max_v[EXP_W-1:0];
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            o_vld <= 1'b0;
            o_exp <= '0;
            o_ovf <= 1'b0;
            o_unf <= 1'b0;
        end else begin
            if (bus.flush)
                o_vld <= 1'b0;
            else if (bus.step)
                o_vld <= n_vld;
            if (bus.step && n_vld && !bus.flush) begin
                // Reaching the all-ones code (infinity) counts as overflow.
                if (r >= max_v) begin
                    o_exp <= bus.to_inf ? max_lo : max_lo - 1'b1;
                    o_ovf <= 1'b1;
                end else begin
                    o_exp <= r[EXP_W-1:0];
                    o_ovf <= 1'b0;
                end
                o_unf <= n_q.unf || (n_q.fmt == FMT_ZERO);
            end
        end
    end

    assign bus.out_vld = o_vld;
    assign bus.out_exp = o_exp;
    assign bus.out_ovf = o_ovf;
    assign bus.out_unf = o_unf;

endmodule

// File: tb/tb_fpu_mul_exp_pipe.sv
// Bench for fpu_mul_exp_pipe: directed vectors, expectations queued at issue, monitor compares on output.
// Latency: checks out_vld appears exactly DEPTH+2 steps after issue.
// Backpressure: exercises step stalls, bubbles, flush and mid-pipe reset.
module tb_fpu_mul_exp_pipe;
    localparam int EXP_W = 11;
    localparam int BIAS  = 1023;
    localparam int LZ_W  = 7;
    localparam int DEPTH = 3;

    logic rclk = 1'b0;
    logic rst  = 1'b1;
    always #5 rclk = ~rclk;

    fpu_mul_exp_pipe_if #(.EXP_W(EXP_W), .LZ_W(LZ_W)) bus ();

`ifdef FPU_MUL_EXP_ERR_INJ_EN
    logic       err_en   = 1'b0;
    logic [3:0] err_ctrl = 4'd0;
`endif

    fpu_mul_exp_pipe #(.EXP_W(EXP_W), .BIAS(BIAS), .LZ_W(LZ_W), .DEPTH(DEPTH)) dut (
        .rclk     (rclk),
        .rst      (rst),
`ifdef FPU_MUL_EXP_ERR_INJ_EN
        .err_en   (err_en),
        .err_ctrl (err_ctrl),
`endif
        .bus      (bus)
    );

    typedef struct {
        int    e;
        int    ovf;
        int    unf;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic adv    = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    // Outputs are new only after an edge that actually advanced the pipe.
    always @(posedge rclk) adv = bus.step && !bus.flush && !rst;

    always @(negedge rclk) begin
        if (adv && bus.out_vld) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_vld", int'(bus.out_vld), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_exp"}, int'(bus.out_exp), e.e);
                chk({e.tag, "_ovf"}, int'(bus.out_ovf), e.ovf);
                chk({e.tag, "_unf"}, int'(bus.out_unf), e.unf);
            end
        end
    end

    task automatic push(input string tag, input int e, input int ovf, input int unf);
        exp_t x;
        x.e = e; x.ovf = ovf; x.unf = unf; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic side(input int lz, input int inc, input int cout, input int ti);
        bus.norm_lz  = lz[LZ_W-1:0];
        bus.norm_inc = inc[0];
        bus.rnd_cout = cout[0];
        bus.to_inf   = ti[0];
    endtask

    // One step-qualified cycle; returns 1 time unit after the edge.
    task automatic cyc(input logic v, input int e1, input int e2, input int fmt);
        bus.in_vld  = v;
        bus.in_exp1 = e1[EXP_W-1:0];
        bus.in_exp2 = e2[EXP_W-1:0];
        bus.in_fmt  = fmt[1:0];
        bus.step    = 1'b1;
        @(posedge rclk);
        #1;
        bus.step   = 1'b0;
        bus.in_vld = 1'b0;
    endtask

    task automatic drain();
        repeat (DEPTH + 3) cyc(1'b0, 0, 0, 0);
    endtask

    task automatic one(input string tag, input int e1, input int e2, input int fmt,
                       input int lz, input int inc, input int cout, input int ti,
                       input int ee, input int eo, input int eu);
        side(lz, inc, cout, ti);
        push(tag, ee, eo, eu);
        cyc(1'b1, e1, e2, fmt);
        drain();
    endtask

    int stall_e1[6] = '{1000, 1100, 500, 2000, 1023, 700};
    int stall_e2[6] = '{1023, 1023, 600, 1000, 1024, 700};
    int stall_ex[6] = '{1000, 1100, 77, 1977, 1024, 377};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.step = 1'b0; bus.flush = 1'b0; bus.in_vld = 1'b0;
        bus.in_exp1 = '0; bus.in_exp2 = '0; bus.in_fmt = '0;
        side(0, 0, 0, 1);
        repeat (2) @(posedge rclk);
        #1;
        chk("rst_vld", int'(bus.out_vld), 0);
        chk("rst_exp", int'(bus.out_exp), 0);
        chk("rst_ovf", int'(bus.out_ovf), 0);
        chk("rst_unf", int'(bus.out_unf), 0);
        rst = 1'b0;

        // Latency: result valid exactly DEPTH+2 steps after issue.
        push("nat", 1023, 0, 0);
        cyc(1'b1, 1023, 1023, 0);
        chk("lat_step1", int'(bus.out_vld), 0);
        for (int k = 2; k <= DEPTH + 2; k++) begin
            cyc(1'b0, 0, 0, 0);
            chk($sformatf("lat_step%0d", k), int'(bus.out_vld), (k == DEPTH + 2) ? 1 : 0);
        end
        drain();

        one("sngl",      1016, 1016, 1, 0, 0, 0, 1,  127, 0, 0);
        one("smuld",     1016, 1016, 2, 0, 0, 0, 1, 1023, 0, 0);
        one("zero",      1500,  700, 3, 0, 0, 0, 1,    0, 0, 1);
        one("ovf_inf",   2046, 2046, 0, 0, 0, 0, 1, 2047, 1, 0);
        one("ovf_fin",   2046, 2046, 0, 0, 0, 0, 0, 2046, 1, 0);
        one("rnd_sat",   1535, 1535, 0, 0, 1, 1, 1, 2047, 1, 0);
        one("below_max", 2046, 1023, 0, 0, 0, 0, 0, 2046, 0, 0);
        one("at_max",    2047, 1023, 0, 0, 0, 0, 0, 2046, 1, 0);
        one("sngl_254",  2032, 1016, 1, 0, 0, 0, 1,  254, 0, 0);
        one("sngl_max",  2040, 1016, 1, 0, 0, 0, 1,  255, 1, 0);
        one("lz_inc",    1100, 1000, 0, 3, 1, 0, 1, 1075, 0, 0);
        one("unf",          1,    1, 0, 5, 0, 0, 1,    0, 0, 1);
        one("unf_rnd",      1,    1, 0, 5, 0, 1, 1,    1, 0, 1);

        // Back-to-back stream with a three-cycle stall once results start flowing.
        side(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            push($sformatf("b2b%0d", i), stall_ex[i], 0, 0);
            cyc(1'b1, stall_e1[i], stall_e2[i], 0);
        end
        repeat (3) begin
            @(posedge rclk);
            #1;
            chk("stall_vld", int'(bus.out_vld), 1);
            chk("stall_exp", int'(bus.out_exp), stall_ex[1]);
        end
        drain();

        // Flush with a simultaneous new op: nothing in flight may emerge.
        cyc(1'b1, 1200, 1000, 0);
        cyc(1'b1, 1300, 1000, 0);
        cyc(1'b1, 1400, 1000, 0);
        bus.flush = 1'b1;
        cyc(1'b1, 1023, 1023, 0);
        bus.flush = 1'b0;
        drain();
        chk("flush_vld", int'(bus.out_vld), 0);
        chk("flush_hold_exp", int'(bus.out_exp), stall_ex[5]);

        // Reset mid-pipe discards in-flight ops and clears the output register.
        one("pre_rst", 1, 1, 0, 5, 0, 1, 1, 1, 0, 1);
        cyc(1'b1, 1500, 1000, 0);
        cyc(1'b1, 1600, 1000, 0);
        cyc(1'b0, 0, 0, 0);
        rst = 1'b1;
        cyc(1'b0, 0, 0, 0);
        chk("mid_rst_vld", int'(bus.out_vld), 0);
        chk("mid_rst_exp", int'(bus.out_exp), 0);
        chk("mid_rst_ovf", int'(bus.out_ovf), 0);
        chk("mid_rst_unf", int'(bus.out_unf), 0);
        rst = 1'b0;
        drain();
        chk("post_rst_vld", int'(bus.out_vld), 0);

`ifdef FPU_MUL_EXP_ERR_INJ_EN
        err_en = 1'b1;
        err_ctrl = 4'd0;
        one("inj_b0", 1023, 1023, 0, 0, 0, 0, 1, 1022, 0, 0);
        err_ctrl = 4'd13;
        one("inj_wrap", 1023, 1023, 0, 0, 0, 0, 1, 1022, 0, 0);
        err_ctrl = 4'd12;
        one("inj_sign", 1023, 1023, 0, 0, 0, 0, 1, 0, 0, 1);
        err_en = 1'b0;
        one("inj_off", 1023, 1023, 0, 0, 0, 0, 1, 1023, 0, 0);
        cyc(1'b1, 1500, 1000, 0);
        cyc(1'b0, 0, 0, 0);
        rst = 1'b1;
        cyc(1'b0, 0, 0, 0);
        chk("inj_rst_vld", int'(bus.out_vld), 0);
        chk("inj_rst_exp", int'(bus.out_exp), 0);
        rst = 1'b0;
        drain();
`endif

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
